// File: rtl/csi2_rx_pkg.sv
// Shared definitions for the CSI-2 receive path: calibration FSM states and
// the delay-line tap width helper.
package csi2_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REWIND  = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    STEP    = 3'd4,
    APPLY   = 3'd5,
    DONE    = 3'd6
  } cal_state_t;

  function automatic int calTapWidth(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  localparam int CAL_DEFAULT_TAPS = 32;
  localparam int CAL_TAP_W        = calTapWidth(CAL_DEFAULT_TAPS);

endpackage

// File: rtl/csi2_lane_eye_tracker.sv
// Per-lane eye tracker: counts sync hits per window, classifies each tap and
// keeps the longest run of good taps, yielding the tap centred on that run.
module csi2_lane_eye_tracker
  import csi2_rx_pkg::*;
#(
  parameter int TAPS          = 32,
  parameter int WINDOW_CYCLES = 4096,
  parameter int MIN_HITS      = 4
) (
  input  logic                         ref_clk_i,
  input  logic                         ref_srst_i,
  input  logic                         i_clear,
  input  logic                         i_clearHits,
  input  logic                         i_count,
  input  logic                         i_evaluate,
  input  logic [calTapWidth(TAPS)-1:0] i_index,
  input  logic                         i_hit,
  output logic [calTapWidth(TAPS)-1:0] o_target,
  output logic                         o_found
);

  localparam int TAP_W = calTapWidth(TAPS);
  localparam int HIT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int LEN_W = $clog2(TAPS + 1);
  localparam logic [HIT_W-1:0] MIN_HITS_V = HIT_W'(MIN_HITS);

  logic [HIT_W-1:0] r_hits;
  logic [HIT_W:0]   w_hitsSum;
  logic [HIT_W-1:0] w_hitsSat;
  logic [HIT_W-1:0] w_hitsFinal;
  logic             w_good;
  logic [LEN_W-1:0] r_runLen;
  logic [LEN_W-1:0] r_bestLen;
  logic [LEN_W-1:0] w_runLenNext;
  logic [LEN_W-1:0] w_bestLenM1;
  logic [TAP_W-1:0] r_runStart;
  logic [TAP_W-1:0] r_bestStart;

  assign w_hitsSum    = {1'b0, r_hits} + {{HIT_W{1'b0}}, i_hit};
  assign w_hitsSat    = w_hitsSum[HIT_W] ? {HIT_W{1'b1}} : w_hitsSum[HIT_W-1:0];
  // The decision includes a hit arriving in the final window cycle.
  assign w_hitsFinal  = i_count ? w_hitsSat : r_hits;
  assign w_good       = (w_hitsFinal >= MIN_HITS_V);
  assign w_runLenNext = r_runLen + LEN_W'(1);
  assign w_bestLenM1  = r_bestLen - LEN_W'(1);

  assign o_found  = (r_bestLen != '0);
  assign o_target = o_found ? (r_bestStart + TAP_W'(w_bestLenM1 >> 1)) : '0;

  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_hits <= '0;
    end else if (i_clearHits) begin
      r_hits <= '0;
    end else if (i_count) begin
      r_hits <= w_hitsSat;
    end
  end

  // Strictly-greater update keeps the first of equal-length runs.
  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_runLen    <= '0;
      r_runStart  <= '0;
      r_bestLen   <= '0;
      r_bestStart <= '0;
    end else if (i_clear) begin
      r_runLen    <= '0;
      r_runStart  <= '0;
      r_bestLen   <= '0;
      r_bestStart <= '0;
    end else if (i_evaluate) begin
      if (w_good) begin
        r_runLen <= w_runLenNext;
        if (r_runLen == '0) begin
          r_runStart <= i_index;
        end
        if (w_runLenNext > r_bestLen) begin
          r_bestLen   <= w_runLenNext;
          r_bestStart <= (r_runLen == '0) ? i_index : r_runStart;
        end
      end else begin
        r_runLen <= '0;
      end
    end
  end

endmodule

// File: rtl/csi2_delay_cal.sv
// D-PHY data-lane delay calibration: sweeps every tap, measures SoT sync hits
// per lane and parks each lane in the middle of its widest good window.
module csi2_delay_cal
  import csi2_rx_pkg::*;
#(
  parameter int DATA_LANES    = 2,
  parameter int TAPS          = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 4096,
  parameter int MIN_HITS      = 4
) (
  input  logic                                    ref_clk_i,
  input  logic                                    ref_srst_i,
  input  logic                                    start_i,
  input  logic [DATA_LANES-1:0]                   sync_hit_i,
  output logic [DATA_LANES-1:0]                   inc_delay_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic [DATA_LANES-1:0]                   lane_ok_o,
  output logic [DATA_LANES*calTapWidth(TAPS)-1:0] tap_o
);

  localparam int TAP_W   = calTapWidth(TAPS);
  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] TAP_MAX    = TAP_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_END = CNT_W'(WINDOW_CYCLES - 1);

  cal_state_t              r_state;
  cal_state_t              w_nextState;
  logic [CNT_W-1:0]        r_cnt;
  logic [TAP_W-1:0]        r_idx;
  logic [TAP_W-1:0]        r_tap [DATA_LANES];
  logic [DATA_LANES-1:0]   r_laneOk;
  logic                    r_done;
  logic [TAP_W-1:0]        w_target [DATA_LANES];
  logic [DATA_LANES-1:0]   w_found;
  logic [DATA_LANES-1:0]   w_tapNz;
  logic [DATA_LANES-1:0]   w_tapMiss;
  logic [DATA_LANES-1:0]   w_inc;
  logic                    w_startAcc;
  logic                    w_sweepBegin;
  logic                    w_settle;
  logic                    w_measure;
  logic                    w_evaluate;

  for (genvar n = 0; n < DATA_LANES; n++) begin : g_lane
    assign w_tapNz[n]   = (r_tap[n] != '0);
    assign w_tapMiss[n] = (r_tap[n] != w_target[n]);
    assign tap_o[n*TAP_W +: TAP_W] = r_tap[n];

    csi2_lane_eye_tracker #(
      .TAPS          (TAPS),
      .WINDOW_CYCLES (WINDOW_CYCLES),
      .MIN_HITS      (MIN_HITS)
    ) u_tracker (
      .ref_clk_i   (ref_clk_i),
      .ref_srst_i  (ref_srst_i),
      .i_clear     (w_sweepBegin),
      .i_clearHits (w_settle),
      .i_count     (w_measure),
      .i_evaluate  (w_evaluate),
      .i_index     (r_idx),
      .i_hit       (sync_hit_i[n]),
      .o_target    (w_target[n]),
      .o_found     (w_found[n])
    );
  end

  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_inc        = '0;
    w_startAcc   = 1'b0;
    w_sweepBegin = 1'b0;
    w_settle     = 1'b0;
    w_measure    = 1'b0;
    w_evaluate   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_startAcc = 1'b1;
          if (|w_tapNz) begin
            w_nextState = REWIND;
          end else begin
            w_nextState  = SETTLE;
            w_sweepBegin = 1'b1;
          end
        end
      end
      // Rewinding means wrapping forward through TAPS-1 back to tap 0.
      REWIND: begin
        if (|w_tapNz) begin
          w_inc = w_tapNz;
        end else begin
          w_nextState  = SETTLE;
          w_sweepBegin = 1'b1;
        end
      end
      SETTLE: begin
        w_settle = 1'b1;
        if (r_cnt == SETTLE_END) begin
          w_nextState = MEASURE;
        end
      end
      MEASURE: begin
        w_measure = 1'b1;
        if (r_cnt == WINDOW_END) begin
          w_evaluate  = 1'b1;
          w_nextState = STEP;
        end
      end
      STEP: begin
        w_inc       = '1;
        w_nextState = (r_idx == TAP_MAX) ? APPLY : SETTLE;
      end
      APPLY: begin
        w_inc = w_tapMiss;
        if (w_tapMiss == '0) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_cnt <= '0;
    end else if (w_nextState != r_state) begin
      r_cnt <= '0;
    end else if (w_settle || w_measure) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_idx <= '0;
    end else if (w_sweepBegin) begin
      r_idx <= '0;
    end else if (r_state == STEP && r_idx != TAP_MAX) begin
      r_idx <= r_idx + TAP_W'(1);
    end
  end

  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      for (int n = 0; n < DATA_LANES; n++) begin
        r_tap[n] <= '0;
      end
    end else begin
      for (int n = 0; n < DATA_LANES; n++) begin
        if (w_inc[n]) begin
          r_tap[n] <= (r_tap[n] == TAP_MAX) ? '0 : r_tap[n] + TAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_laneOk <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_sweepBegin) begin
        r_laneOk <= '0;
      end else if (r_state == APPLY) begin
        r_laneOk <= r_laneOk | w_found;
      end
      if (w_startAcc) begin
        r_done <= 1'b0;
      end else if (r_state == APPLY && w_nextState == DONE) begin
        r_done <= 1'b1;
      end
    end
  end

  assign inc_delay_o = w_inc;
  assign busy_o      = (r_state != IDLE) && (r_state != DONE);
  assign done_o      = r_done;
  assign lane_ok_o   = r_laneOk;

endmodule

// File: tb/tb_csi2_delay_cal.sv
// Bench for csi2_delay_cal: a delay-line/receiver model produces sync hits per
// tap, and a scoreboard of expected calibration results is checked at done_o.
module tb_csi2_delay_cal;

  localparam int LANES    = 2;
  localparam int TAPS     = 32;
  localparam int SETTLE   = 8;
  localparam int WINDOW   = 60;
  localparam int MIN_HITS = 4;
  localparam int TAP_W    = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   startIn = 1'b0;
  logic [LANES-1:0]       hitIn = '0;
  logic [LANES-1:0]       incOut;
  logic                   busyOut;
  logic                   doneOut;
  logic [LANES-1:0]       laneOkOut;
  logic [LANES*TAP_W-1:0] tapOut;

  always #5 clk = ~clk;

  csi2_delay_cal #(
    .DATA_LANES    (LANES),
    .TAPS          (TAPS),
    .SETTLE_CYCLES (SETTLE),
    .WINDOW_CYCLES (WINDOW),
    .MIN_HITS      (MIN_HITS)
  ) dut (
    .ref_clk_i   (clk),
    .ref_srst_i  (rst),
    .start_i     (startIn),
    .sync_hit_i  (hitIn),
    .inc_delay_o (incOut),
    .busy_o      (busyOut),
    .done_o      (doneOut),
    .lane_ok_o   (laneOkOut),
    .tap_o       (tapOut)
  );

  typedef struct {
    int         tap0;
    int         tap1;
    int         pulses0;
    int         pulses1;
    logic [1:0] laneOk;
  } exp_t;

  exp_t sb[$];
  int   periodTab [LANES][TAPS];
  bit   burstTab [LANES][TAPS];
  int   modelTap [LANES];
  int   pulseCnt [LANES];
  int   offset [LANES];
  int   prevTap [LANES];
  int   gcnt = 0;
  int   checks = 0;
  int   failures = 0;

  // Delay element + receiver model: the tap follows inc pulses; hits come from
  // a free-running train per tap, plus an optional burst while settling.
  initial begin
    for (int l = 0; l < LANES; l++) begin
      modelTap[l] = 0;
      pulseCnt[l] = 0;
      offset[l]   = 0;
      prevTap[l]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) begin
        if (rst) begin
          modelTap[l] = 0;
          pulseCnt[l] = 0;
          offset[l]   = 0;
        end else if (incOut[l]) begin
          modelTap[l] = (modelTap[l] + 1) % TAPS;
          pulseCnt[l]++;
          offset[l] = 0;
        end else begin
          offset[l]++;
        end
        hitIn[l] = ((periodTab[l][modelTap[l]] != 0) && (gcnt % periodTab[l][modelTap[l]] == 0)) ||
                   (burstTab[l][modelTap[l]] && offset[l] >= 1 && offset[l] <= SETTLE);
      end
      gcnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearTables();
    for (int l = 0; l < LANES; l++) begin
      for (int t = 0; t < TAPS; t++) begin
        periodTab[l][t] = 0;
        burstTab[l][t]  = 1'b0;
      end
    end
  endtask

  task automatic setRange(input int l, input int lo, input int hi, input int period, input bit burst);
    for (int t = lo; t <= hi; t++) begin
      periodTab[l][t] = period;
      burstTab[l][t]  = burst;
    end
  endtask

  task automatic modelLane(input int l, output int target, output bit ok);
    int runLen;
    int runStart;
    int bestLen;
    int bestStart;
    bit good;
    runLen = 0; runStart = 0; bestLen = 0; bestStart = 0;
    for (int t = 0; t < TAPS; t++) begin
      good = (periodTab[l][t] != 0) && ((WINDOW / periodTab[l][t]) >= MIN_HITS);
      if (good) begin
        if (runLen == 0) runStart = t;
        runLen++;
        if (runLen > bestLen) begin
          bestLen   = runLen;
          bestStart = runStart;
        end
      end else begin
        runLen = 0;
      end
    end
    ok     = (bestLen > 0);
    target = ok ? bestStart + (bestLen - 1) / 2 : 0;
  endtask

  task automatic pulseStart();
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
  endtask

  task automatic applyStimulus();
    exp_t e;
    int   tgt [LANES];
    bit   ok [LANES];
    int   pulses [LANES];
    for (int l = 0; l < LANES; l++) begin
      modelLane(l, tgt[l], ok[l]);
      pulses[l]  = ((prevTap[l] == 0) ? 0 : TAPS - prevTap[l]) + TAPS + tgt[l];
      prevTap[l] = tgt[l];
      pulseCnt[l] = 0;
    end
    e.tap0 = tgt[0]; e.tap1 = tgt[1];
    e.pulses0 = pulses[0]; e.pulses1 = pulses[1];
    e.laneOk = {ok[1], ok[0]};
    sb.push_back(e);
    pulseStart();
  endtask

  task automatic waitAndCheck(input string name);
    exp_t e;
    for (int i = 0; i < 6000 && !doneOut; i++) @(negedge clk);
    checkOutput({name, ".done"}, 64'(doneOut), 64'd1);
    repeat (2) @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput({name, ".sbEmpty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({name, ".tap0"}, 64'(tapOut[0 +: TAP_W]), 64'(e.tap0));
      checkOutput({name, ".tap1"}, 64'(tapOut[TAP_W +: TAP_W]), 64'(e.tap1));
      checkOutput({name, ".laneOk"}, 64'(laneOkOut), 64'(e.laneOk));
      checkOutput({name, ".pulses0"}, 64'(pulseCnt[0]), 64'(e.pulses0));
      checkOutput({name, ".pulses1"}, 64'(pulseCnt[1]), 64'(e.pulses1));
      checkOutput({name, ".modelTap0"}, 64'(tapOut[0 +: TAP_W]), 64'(modelTap[0]));
      checkOutput({name, ".modelTap1"}, 64'(tapOut[TAP_W +: TAP_W]), 64'(modelTap[1]));
      checkOutput({name, ".busy"}, 64'(busyOut), 64'd0);
    end
  endtask

  initial begin
    clearTables();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst.inc", 64'(incOut), 64'd0);
    checkOutput("rst.busy", 64'(busyOut), 64'd0);
    checkOutput("rst.done", 64'(doneOut), 64'd0);
    checkOutput("rst.laneOk", 64'(laneOkOut), 64'd0);
    checkOutput("rst.tap", 64'(tapOut), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle.busy", 64'(busyOut), 64'd0);

    // Two lanes with distinct good windows.
    clearTables();
    setRange(0, 10, 19, 6, 1'b0);
    setRange(1, 3, 8, 6, 1'b0);
    applyStimulus();
    checkOutput("runA.busyAfterStart", 64'(busyOut), 64'd1);
    waitAndCheck("runA");

    // Equal-length runs keep the first; dead lane; restart from DONE rewinds;
    // a start while busy is ignored.
    clearTables();
    setRange(0, 2, 4, 6, 1'b0);
    setRange(0, 20, 22, 6, 1'b0);
    applyStimulus();
    checkOutput("runB.doneCleared", 64'(doneOut), 64'd0);
    checkOutput("runB.busy", 64'(busyOut), 64'd1);
    repeat (100) @(negedge clk);
    pulseStart();
    checkOutput("runB.busyIgnore", 64'(busyOut), 64'd1);
    waitAndCheck("runB");

    // Run touching the top tap; dead lane starting from tap 0.
    clearTables();
    setRange(0, 28, 31, 6, 1'b0);
    applyStimulus();
    waitAndCheck("runC");

    // Hit threshold edges and hits arriving only while settling.
    clearTables();
    setRange(0, 5, 5, 20, 1'b0);
    setRange(0, 6, 8, 15, 1'b0);
    setRange(0, 10, 12, 20, 1'b1);
    setRange(1, 0, 31, 6, 1'b0);
    applyStimulus();
    waitAndCheck("runD");

    // Reset in the middle of measuring tap 7 (lane0 rewinds 25 from tap 7).
    clearTables();
    pulseCnt[0] = 0;
    pulseCnt[1] = 0;
    pulseStart();
    for (int i = 0; i < 4000 && pulseCnt[0] < 32; i++) @(negedge clk);
    checkOutput("rstMid.reachTap7", 64'(pulseCnt[0] >= 32), 64'd1);
    repeat (SETTLE + 20) @(negedge clk);
    checkOutput("rstMid.busyBefore", 64'(busyOut), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMid.inc", 64'(incOut), 64'd0);
    checkOutput("rstMid.busy", 64'(busyOut), 64'd0);
    checkOutput("rstMid.done", 64'(doneOut), 64'd0);
    checkOutput("rstMid.laneOk", 64'(laneOkOut), 64'd0);
    checkOutput("rstMid.tap", 64'(tapOut), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("postRst.pulses0", 64'(pulseCnt[0]), 64'd0);
    checkOutput("postRst.pulses1", 64'(pulseCnt[1]), 64'd0);
    checkOutput("postRst.busy", 64'(busyOut), 64'd0);
    checkOutput("postRst.tap", 64'(tapOut), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi2_delay_cal.md
CSI2_DELAY_CAL -- requirements
Module: csi2_delay_cal

Interface
REQ-001 Parameter DATA_LANES, default 2, number of D-PHY data lanes calibrated.
REQ-002 Parameter TAPS, default 32, delay-line taps per lane; the delay line wraps from TAPS-1 to 0 on increment.
REQ-003 Parameter SETTLE_CYCLES, default 16, cycles ignored after every tap change.
REQ-004 Parameter WINDOW_CYCLES, default 4096, measurement window per tap.
REQ-005 Parameter MIN_HITS, default 4, minimum sync hits in a window for a tap to count as good.
REQ-006 ref_clk_i  input  1  calibration clock.
REQ-007 ref_srst_i  input  1  reset, asynchronous, active-high; clock ref_clk_i.
REQ-008 start_i  input  1  single-cycle pulse that requests a calibration run.
REQ-009 sync_hit_i  input  DATA_LANES  per-lane single-cycle pulse on each correctly received SoT sync byte 0xB8.
REQ-010 inc_delay_o  output  DATA_LANES  per-lane single-cycle tap-increment pulse to the lane delay element.
REQ-011 busy_o  output  1  high while a run is in progress.
REQ-012 done_o  output  1  high from run completion until the next accepted start_i.
REQ-013 lane_ok_o  output  DATA_LANES  per-lane flag, set when at least one good tap was found.
REQ-014 tap_o  output  DATA_LANES*$clog2(TAPS)  current tap per lane; lane n occupies slice n.

Function
REQ-015 FSM states: IDLE, REWIND, SETTLE, MEASURE, STEP, APPLY, DONE.
REQ-016 IDLE or DONE with start_i -> REWIND if any tap_o is nonzero, else SETTLE with sweep index 0; start_i in any other state is ignored.
REQ-017 REWIND issues one inc_delay_o pulse per cycle to each lane with a nonzero tap until every tap is 0, then moves to SETTLE.
REQ-018 SETTLE lasts exactly SETTLE_CYCLES cycles; sync_hit_i is ignored.
REQ-019 MEASURE lasts exactly WINDOW_CYCLES cycles and counts sync_hit_i per lane in a saturating counter $clog2(WINDOW_CYCLES+1) bits wide.
REQ-020 At the end of MEASURE, a tap is good when hits >= MIN_HITS. A good tap makes run_len+1 and records run_start when run_len was 0; a bad tap sets run_len to 0.
REQ-021 best_len/best_start update only when the new run_len exceeds best_len strictly, so the first of equal-length runs is kept; runs do not wrap across tap TAPS-1 -> 0.
REQ-022 STEP issues exactly one inc_delay_o pulse to all lanes. If the index was TAPS-1, go to APPLY (the delay line is back at tap 0); else increment the index and go to SETTLE.
REQ-023 APPLY per lane: target = best_start + ((best_len-1)>>1) when best_len>0, else 0. Issue one pulse per cycle per lane until tap equals target, then go to DONE when all lanes match.
REQ-024 Each tap_o tracks its lane modulo TAPS on every inc_delay_o pulse; never more than one pulse per lane per cycle.
REQ-025 lane_ok_o is cleared on entry to SETTLE from IDLE/DONE/REWIND and set in APPLY when best_len>0.
REQ-026 busy_o = state not in {IDLE, DONE}; done_o is asserted on entry to DONE.

Reset
REQ-027 On ref_srst_i: state IDLE, all counters/run trackers 0, inc_delay_o 0, busy_o 0, done_o 0, lane_ok_o 0, tap_o 0.
REQ-028 The lane delay elements are reset to tap 0 by the same ref_srst_i, so tap_o matches hardware after reset mid-operation.

Structure
REQ-029 Shared package csi2_rx_pkg holds the calibration FSM state enum and the tap-width constant.
REQ-030 Sub-module csi2_lane_eye_tracker (hit counter, good/bad decision, run/best tracking, target computation) is instantiated DATA_LANES times; the FSM stays in csi2_delay_cal.

Verification
REQ-031 Lane0 good taps 10..19, lane1 good taps 3..8 -> done_o; tap_o 14 and 5; inc pulses 32+14 and 32+5; lane_ok_o=2'b11.
REQ-032 Lane1 with no hits -> lane1 tap_o 0, lane_ok_o[1]=0, done_o=1, lane1 total pulses 32.
REQ-033 Lane0 good runs 2..4 and 20..22 -> tap_o 3; good run 28..31 -> tap_o 29.
REQ-034 start_i in DONE with taps 14/5 -> 18/27 REWIND pulses, then a full sweep; start_i while busy_o=1 -> no effect.
REQ-035 ref_srst_i asserted mid-MEASURE at tap 7 -> next cycle all outputs 0, state IDLE, no further inc_delay_o pulses.
REQ-036 Exactly MIN_HITS-1=3 hits in a window -> tap bad; 4 hits -> good; hits during SETTLE are not counted.
